fir_filter_param: RTL
=====================

Name: fir_filter_param

Overview:
Parametrised, run-time-programmable FIR filter for the audio path (mic/BRAM playback to volume_control/pwm), superseding the fixed 31-tap, 8-bit filter.
- Generalised in tap count, data width, coefficient width and output scaling.
- Adds a ready/valid handshake, overrun detection, a writable coefficient bank, round-half-up and output saturation.
- One multiply-accumulate per clock; one sample processed at a time.

Parameters:
NUM_TAPS, 31, number of taps (2..64)
DATA_WIDTH, 8, signed input/output sample width
COEFF_WIDTH, 12, signed coefficient width
SHIFT, 10, output scaling: y = acc >>> SHIFT (constraint: SHIFT <= COEFF_WIDTH-2)

Ports:
clk_in  input  1  system clock (100 MHz)
rst_n_in  input  1  synchronous active-low reset
sample_in  input  DATA_WIDTH  signed input sample
sample_valid_in  input  1  sample_in valid this cycle
ready_out  output  1  filter idle; a sample or coefficient write will be accepted
coeff_we_in  input  1  coefficient write strobe
coeff_addr_in  input  clog2(NUM_TAPS)  tap index to write
coeff_data_in  input  COEFF_WIDTH  signed coefficient value
bypass_in  input  1  1 = output the newest sample, unfiltered
y_out  output  DATA_WIDTH  signed filtered sample
y_valid_out  output  1  one-cycle pulse: y_out updated
sat_out  output  1  valid with y_valid_out: this result was clipped
overrun_out  output  1  sticky: a sample arrived while busy
coeff_err_out  output  1  sticky: coefficient write while busy or address >= NUM_TAPS

Behaviour:
- Reset (rst_n_in=0 at a clock edge; any state, including mid-MAC):
  - State IDLE; delay line, accumulator and write pointer zeroed.
  - coeff[0]=2^SHIFT, all other coeffs 0 (identity filter).
  - y_out=0, y_valid_out=0, sat_out=0, overrun_out=0, coeff_err_out=0, ready_out=1 in the cycle after reset.
- ACC_WIDTH = DATA_WIDTH+COEFF_WIDTH+clog2(NUM_TAPS). All products and sums are signed, with no internal overflow.
- FSM:
  - IDLE: ready_out=1. On sample_valid_in, write sample_in to delay[wr_ptr], advance wr_ptr (mod NUM_TAPS, wraps), clear acc, set k=0, go to MAC.
  - MAC: ready_out=0. Exactly NUM_TAPS cycles. Each cycle: acc += coeff[k] * delay[newest-k mod NUM_TAPS]; k++. After k=NUM_TAPS-1, go to OUT.
  - OUT: ready_out=0. One cycle.
    - r = (acc + 2^(SHIFT-1)) >>> SHIFT (no rounding term when SHIFT=0).
    - y_out = r clipped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; sat_out=1 if clipped.
    - bypass_in=1 (sampled here): y_out = newest sample and sat_out=0.
    - Register y_out, pulse y_valid_out, return to IDLE.
- Latency: y_valid_out is high exactly NUM_TAPS+1 cycles after the accepting cycle, for one cycle. y_out holds its value until the next result. Minimum sample spacing is NUM_TAPS+1 cycles; a sample coincident with y_valid_out is accepted (state already IDLE).
- sample_valid_in while ready_out=0: the sample is dropped, no state change, overrun_out set until reset.
- Coefficient writes:
  - Accepted only when ready_out=1 and coeff_addr_in < NUM_TAPS; the new value is used from the next accepted sample.
  - Writes otherwise are dropped and set coeff_err_out.
  - sample_valid_in and coeff_we_in in the same IDLE cycle: both take effect, and the write applies to this sample's computation.
- Delay-line ordering: tap 0 multiplies the newest sample, tap NUM_TAPS-1 the oldest. Before NUM_TAPS samples have arrived, missing history reads 0.

Test Plan:
- Reset, default coeffs; feed 100 then 0,0,... at 40-cycle spacing -> y_out = 100, 0, 0..., y_valid_out 32 cycles after each accept, sat_out=0.
- Load 31 low-pass coeffs (-1,-1,-3,-5,-6,-7,-5,0,10,26,46,69,91,110,123,128,123,...,-1), feed impulse 100 then zeros -> outputs 0,0,0,-1(=round(-0.49)->0)... exact check: output 15 = 13, outputs 14 and 16 = 12, output 0 = 0.
- coeff[0..3]=2047, others 0; feed 127 four times -> fourth y_out=127, sat_out=1. Same test with -128 -> y_out=-128, sat_out=1.
- Assert sample_valid_in 5 cycles after an accept -> sample ignored, overrun_out=1 and stays 1; next result unaffected. A coeff write during MAC -> coeff_err_out=1, coeff unchanged.
- bypass_in=1 with low-pass coeffs; feed 37 -> y_out=37 after NUM_TAPS+1 cycles.
- Deassert rst_n_in mid-MAC -> next cycle ready_out=1 and y_out=0, no y_valid_out pulse; subsequent impulse 50 -> y_out=50 (identity coeffs restored).

Source files
------------

// File: rtl/fir_filter_param.sv
// Run-time programmable FIR for the audio path: one MAC per clock, round-half-up,
// output saturation, ready/valid sample handshake and a writable coefficient bank.
//   state  | meaning
//   S_IDLE | ready for a sample or coefficient write
//   S_MAC  | NUM_TAPS multiply-accumulate cycles, newest sample first
//   S_OUT  | round, clip (or bypass), register y_out and pulse y_valid_out
module fir_filter_param #(
  parameter int NUM_TAPS    = 31,
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 12,
  parameter int SHIFT       = 10
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic signed [DATA_WIDTH-1:0]      sample_in,
  input  logic                              sample_valid_in,
  output logic                              ready_out,
  input  logic                              coeff_we_in,
  input  logic        [$clog2(NUM_TAPS)-1:0] coeff_addr_in,
  input  logic signed [COEFF_WIDTH-1:0]     coeff_data_in,
  input  logic                              bypass_in,
  output logic signed [DATA_WIDTH-1:0]      y_out,
  output logic                              y_valid_out,
  output logic                              sat_out,
  output logic                              overrun_out,
  output logic                              coeff_err_out
);

  localparam int AW     = $clog2(NUM_TAPS);
  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam int ACC_W  = DATA_WIDTH + COEFF_WIDTH + AW;

  localparam logic [AW-1:0]               LAST  = AW'(NUM_TAPS - 1);
  localparam logic [AW:0]                 TAPS  = (AW + 1)'(NUM_TAPS);
  localparam logic signed [ACC_W-1:0]     RND   = ACC_W'((1 << SHIFT) >> 1);
  localparam logic signed [ACC_W-1:0]     Y_MAX = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0]     Y_MIN = ~Y_MAX;
  localparam logic signed [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(1 << SHIFT);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                         state;
  logic signed [DATA_WIDTH-1:0]   delay_q [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0]  coeff_q [NUM_TAPS];
  logic [AW-1:0]                  wr_ptr;
  logic [AW-1:0]                  rd_ptr;
  logic [AW-1:0]                  newest;
  logic [AW-1:0]                  k;
  logic signed [ACC_W-1:0]        acc;

  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        acc_rnd;
  logic signed [ACC_W-1:0]        acc_shr;

  assign prod      = PROD_W'(delay_q[rd_ptr]) * PROD_W'(coeff_q[k]);
  assign acc_rnd   = acc + RND;
  assign acc_shr   = acc_rnd >>> SHIFT;
  assign ready_out = (state == S_IDLE);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      newest        <= '0;
      k             <= '0;
      acc           <= '0;
      y_out         <= '0;
      y_valid_out   <= 1'b0;
      sat_out       <= 1'b0;
      overrun_out   <= 1'b0;
      coeff_err_out <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        delay_q[i] <= '0;
        coeff_q[i] <= (i == 0) ? UNITY : '0;
      end
    end else begin
      y_valid_out <= 1'b0;

      // An IDLE-cycle write lands before the first MAC cycle, so it applies to a coincident sample.
      if (coeff_we_in) begin
        if (state == S_IDLE && {1'b0, coeff_addr_in} < TAPS)
          coeff_q[coeff_addr_in] <= coeff_data_in;
        else
          coeff_err_out <= 1'b1;
      end

      if (sample_valid_in && state != S_IDLE)
        overrun_out <= 1'b1;

      case (state)
        S_IDLE: begin
          if (sample_valid_in) begin
            delay_q[wr_ptr] <= sample_in;
            newest          <= wr_ptr;
            rd_ptr          <= wr_ptr;
            wr_ptr          <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            acc             <= '0;
            k               <= '0;
            state           <= S_MAC;
          end
        end
        S_MAC: begin
          acc    <= acc + ACC_W'(prod);
          k      <= k + 1'b1;
          rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
          if (k == LAST)
            state <= S_OUT;
        end
        S_OUT: begin
          y_valid_out <= 1'b1;
          state       <= S_IDLE;
          if (bypass_in) begin
            y_out   <= delay_q[newest];
            sat_out <= 1'b0;
          end else if (acc_shr > Y_MAX) begin
            y_out   <= Y_MAX[DATA_WIDTH-1:0];
            sat_out <= 1'b1;
          end else if (acc_shr < Y_MIN) begin
            y_out   <= Y_MIN[DATA_WIDTH-1:0];
            sat_out <= 1'b1;
          end else begin
            y_out   <= acc_shr[DATA_WIDTH-1:0];
            sat_out <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
